bcd_down_counter: RTL and testbench

- Cascadable multi-digit BCD down counter: the decrementing counterpart of the team's BCD up counter.
- Used for countdown timers and presettable delay generators in the same display and timing datapath.
- Loads a BCD preset, decrements by one per enabled clock, and exposes the following:
  - a combinational zero flag;
  - a registered borrow pulse on wrap.
- Optionally saturates at zero instead of wrapping.

---
 rtl/bcd_down_counter_pkg.sv | 20 ++
 rtl/bcd_down_digit.sv | 30 +++
 rtl/bcd_down_counter.sv | 67 ++++++
 tb/tb_bcd_down_counter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/bcd_down_counter_pkg.sv
// Shared BCD constants and digit helpers for the BCD counter family.
// Contents: DIGIT_W (bits per digit), BCD_MAX / BCD_ZERO digit codes,
//           bcd_clamp() which limits a raw nibble to a legal BCD digit.
package bcd_down_counter_pkg;

  localparam int          DIGIT_W  = 4;
  localparam logic [3:0]  BCD_MAX  = 4'b1001;
  localparam logic [3:0]  BCD_ZERO = 4'b0000;

  // Nibbles A..F are not BCD; pin them to the largest legal digit.
  function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

  // One step down within a digit; 0 rolls to 9 (the borrow goes upward).
  function automatic logic [DIGIT_W-1:0] bcd_dec(input logic [DIGIT_W-1:0] d);
    return (d == BCD_ZERO) ? BCD_MAX : d - 4'd1;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// Single BCD digit of the down counter: presettable, decrements on dec_in.
// Ports: clk, reset (sync, active-low), load, load_digit[3:0], dec_in in;
//        digit[3:0] (registered), borrow_out (digit == 0, combinational) out.
module bcd_down_digit
  import bcd_down_counter_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_digit,
  input  logic               dec_in,
  output logic [DIGIT_W-1:0] digit,
  output logic               borrow_out
);

  // Load wins over dec_in so a simultaneous enable never decrements a preset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      digit <= BCD_ZERO;
    end else if (load) begin
      digit <= bcd_clamp(load_digit);
    end else if (dec_in) begin
      digit <= bcd_dec(digit);
    end
  end

  // A zero digit lets the decrement ripple into the next digit up.
  assign borrow_out = (digit == BCD_ZERO);

endmodule

// File: rtl/bcd_down_counter.sv
// Cascadable multi-digit BCD down counter with preset, wrap or saturate at zero.
// Ports: clk, reset (sync, active-low), load, load_value, down_enable in;
//        bcd (registered), zero/busy (combinational), borrow (registered pulse) out.
module bcd_down_counter
  import bcd_down_counter_pkg::*;
#(
  parameter int          DIGITS = 2,
  parameter int unsigned WRAP   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] load_value,
  input  logic                      down_enable,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                      zero,
  output logic                      busy,
  output logic                      borrow
);

  logic [DIGITS-1:0] digit_zero;
  logic [DIGITS-1:0] dec_chain;
  logic              all_zero;
  logic              wrap_en;
  logic              hold_at_zero;

  assign wrap_en      = (WRAP != 0);
  assign all_zero     = &digit_zero;
  // In saturating mode the all-zero state must not roll over, so the whole
  // decrement chain is gated off at its root.
  assign hold_at_zero = all_zero & ~wrap_en;

  genvar i;
  generate
    for (i = 0; i < DIGITS; i++) begin : g_digit
      if (i == 0) begin : g_lsd
        assign dec_chain[0] = down_enable & ~hold_at_zero;
      end else begin : g_upper
        // Digit i moves only when every lower digit is zero.
        assign dec_chain[i] = dec_chain[i-1] & digit_zero[i-1];
      end

      bcd_down_digit u_digit (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_digit (load_value[DIGIT_W*i +: DIGIT_W]),
        .dec_in     (dec_chain[i]),
        .digit      (bcd[DIGIT_W*i +: DIGIT_W]),
        .borrow_out (digit_zero[i])
      );
    end
  endgenerate

  // Pulse only on an edge that takes the all-zero count to all nines.
  always_ff @(posedge clk) begin
    if (!reset) begin
      borrow <= 1'b0;
    end else begin
      borrow <= ~load & down_enable & all_zero & wrap_en;
    end
  end

  assign zero = all_zero;
  assign busy = ~all_zero;

endmodule

// File: tb/tb_bcd_down_counter.sv
module tb_bcd_down_counter;

  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;
  localparam int MAXV   = 99;

  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic [W-1:0] load_value;
  logic         down_enable;

  logic [W-1:0] bcd_w, bcd_s;
  logic         zero_w, zero_s, busy_w, busy_s, borrow_w, borrow_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_down_counter #(.DIGITS(DIGITS), .WRAP(1)) u_wrap (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .down_enable(down_enable), .bcd(bcd_w), .zero(zero_w), .busy(busy_w),
    .borrow(borrow_w)
  );

  bcd_down_counter #(.DIGITS(DIGITS), .WRAP(0)) u_sat (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .down_enable(down_enable), .bcd(bcd_s), .zero(zero_s), .busy(busy_s),
    .borrow(borrow_s)
  );

  typedef struct {
    int value_w;
    int borrow_w;
    int value_s;
    int borrow_s;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: count kept as a plain integer 0..99.
  int m_w = 0, m_s = 0, b_w = 0, b_s = 0;

  function automatic int preset_to_int(input logic [W-1:0] v);
    int d0, d1;
    d0 = int'(v[3:0]);
    d1 = int'(v[7:4]);
    if (d0 > 9) d0 = 9;
    if (d1 > 9) d1 = 9;
    return d1 * 10 + d0;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input int n);
    logic [W-1:0] r;
    r[3:0] = 4'((n % 10));
    r[7:4] = 4'((n / 10) % 10);
    return r;
  endfunction

  // Apply one edge worth of inputs, then advance the model and queue the result.
  task automatic step(input logic r, input logic l, input logic [W-1:0] lv, input logic en);
    reset       = r;
    load        = l;
    load_value  = lv;
    down_enable = en;
    @(posedge clk);
    if (!r) begin
      m_w = 0; m_s = 0; b_w = 0; b_s = 0;
    end else if (l) begin
      m_w = preset_to_int(lv); m_s = m_w; b_w = 0; b_s = 0;
    end else if (en) begin
      if (m_w == 0) begin m_w = MAXV; b_w = 1; end
      else begin m_w = m_w - 1; b_w = 0; end
      if (m_s != 0) m_s = m_s - 1;
      b_s = 0;
    end else begin
      b_w = 0; b_s = 0;
    end
    exp_q.push_back('{value_w: m_w, borrow_w: b_w, value_s: m_s, borrow_s: b_s});
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle presents an output; compare on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("wrap_bcd",    int'(bcd_w),    int'(int_to_bcd(e.value_w)));
      check("wrap_zero",   int'(zero_w),   (e.value_w == 0) ? 1 : 0);
      check("wrap_busy",   int'(busy_w),   (e.value_w != 0) ? 1 : 0);
      check("wrap_borrow", int'(borrow_w), e.borrow_w);
      check("sat_bcd",     int'(bcd_s),    int'(int_to_bcd(e.value_s)));
      check("sat_zero",    int'(zero_s),   (e.value_s == 0) ? 1 : 0);
      check("sat_busy",    int'(busy_s),   (e.value_s != 0) ? 1 : 0);
      check("sat_borrow",  int'(borrow_s), e.borrow_s);
    end
  end

  initial begin
    reset = 1'b0; load = 1'b0; load_value = '0; down_enable = 1'b0;
    @(posedge clk); #1;

    // Reset overrides a pending load.
    step(1'b0, 1'b1, 8'h57, 1'b0);
    step(1'b0, 1'b1, 8'h57, 1'b0);

    // Load then count 12, 11, 10, 09.
    step(1'b1, 1'b1, 8'h12, 1'b0);
    repeat (3) step(1'b1, 1'b0, 8'h00, 1'b1);

    // Wrap / saturate from 01 through zero.
    step(1'b1, 1'b1, 8'h01, 1'b0);
    repeat (4) step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0);

    // Clamp, and load beats down_enable.
    step(1'b1, 1'b1, 8'hAF, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0);

    // Reset in the middle of a countdown, then wrap from zero.
    step(1'b1, 1'b1, 8'h50, 1'b0);
    repeat (5) step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);

    // Randomized traffic; small presets make zero crossings frequent.
    for (int n = 0; n < 400; n++) begin
      logic r, l, en;
      logic [W-1:0] lv;
      r  = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      l  = ($urandom_range(0, 99) < 12) ? 1'b1 : 1'b0;
      en = ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0;
      lv = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255))
                                       : 8'($urandom_range(0, 3));
      step(r, l, lv, en);
    end
    step(1'b1, 1'b0, 8'h00, 1'b0);

    // Let the monitor drain, bounded.
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
    @(negedge clk); #1;
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
